// File: rtl/simple_uart_rx.sv
// simple_uart_rx: 8N1 serial receiver feeding a first-word-fall-through byte FIFO,
// with sticky overrun and framing error flags.
module simple_uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16,
    parameter int FIFO_AW      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx,
    input  logic               read_en,
    output logic [7:0]         read_data,
    output logic               rx_valid,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overrun,
    output logic               frame_err,
    input  logic               clear_err
);
    localparam int CW = $clog2(10 * CLKS_PER_BIT);
    localparam logic [CW-1:0] IDLE_LAST = CW'(10 * CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               rx_meta_q, rx_s_q;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               ovr_q, ovr_d, fe_q, fe_d;
    logic               stop_done, full, push, pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= WAIT_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovr_q     <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            wptr_q    <= wptr_q + FIFO_AW'(push);
            rptr_q    <= rptr_q + FIFO_AW'(pop);
            count_q   <= count_d;
            ovr_q     <= ovr_d;
            fe_q      <= fe_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= shift_q;
    end

    // WAIT_IDLE demands a full frame time of idle so a frame tail is never taken as a start bit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            WAIT_IDLE: begin
                if (!rx_s_q) cnt_d = '0;
                else if (cnt_q == IDLE_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? IDLE : WAIT_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = WAIT_IDLE;
            end
        endcase
    end

    always_comb begin
        stop_done = (state_q == STOP) && (cnt_q == BIT_LAST);
        full      = (count_q == FULL_CNT);
        pop       = read_en && (count_q != '0);
        push      = stop_done && rx_s_q && (!full || pop);
        count_d   = count_q + (FIFO_AW + 1)'(push) - (FIFO_AW + 1)'(pop);
        ovr_d     = (stop_done && rx_s_q && full && !pop) || (ovr_q && !clear_err);
        fe_d      = (stop_done && !rx_s_q) || (fe_q && !clear_err);
    end

    assign rx_valid   = (count_q != '0);
    assign read_data  = rx_valid ? mem_q[rptr_q] : 8'h00;
    assign fifo_count = count_q;
    assign overrun    = ovr_q;
    assign frame_err  = fe_q;
endmodule

// File: tb/tb_simple_uart_rx.sv
// tb_simple_uart_rx: directed bench for simple_uart_rx at 8 clocks per bit.
module tb_simple_uart_rx;
    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       read_en = 1'b0;
    logic       clear_err = 1'b0;
    logic [7:0] read_data;
    logic       rx_valid;
    logic [4:0] fifo_count;
    logic       overrun;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int rise_cyc = 0;
    logic rv_prev = 1'b0;

    simple_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16), .FIFO_AW(4)) dut (
        .clk(clk), .reset(reset), .rx(rx), .read_en(read_en),
        .read_data(read_data), .rx_valid(rx_valid), .fifo_count(fifo_count),
        .overrun(overrun), .frame_err(frame_err), .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && !rv_prev && rise_cyc == 0) rise_cyc <= cyc;
        rv_prev <= rx_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_bit;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic pulse_read();
        read_en = 1'b1;
        tick(1);
        read_en = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        chk(tag, 32'(read_data), 32'(exp));
        pulse_read();
    endtask

    initial begin
        int lat;
        tick(3);
        chk("rst_valid", 32'(rx_valid), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_data", 32'(read_data), 0);
        chk("rst_ovr", 32'(overrun), 0);
        chk("rst_fe", 32'(frame_err), 0);
        reset = 1'b0;
        tick(90);

        fall_cyc = cyc;
        send(8'h55, 1'b1);
        lat = rise_cyc - fall_cyc;
        checks++;
        assert (lat >= 76 && lat <= 80) else begin
            errors++;
            $error("FAIL latency: observed %0d expected 76..80", lat);
        end
        chk("b55_valid", 32'(rx_valid), 1);
        chk("b55_count", 32'(fifo_count), 1);
        pop_chk("b55_data", 8'h55);
        chk("pop_valid", 32'(rx_valid), 0);
        chk("pop_count", 32'(fifo_count), 0);
        chk("pop_data", 32'(read_data), 0);
        pulse_read();
        chk("empty_read_count", 32'(fifo_count), 0);

        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'hA5, 1'b1);
        chk("b2b_count", 32'(fifo_count), 3);
        pop_chk("b2b_0", 8'h00);
        pop_chk("b2b_1", 8'hFF);
        pop_chk("b2b_2", 8'hA5);
        chk("b2b_ovr", 32'(overrun), 0);
        chk("b2b_fe", 32'(frame_err), 0);

        for (int i = 1; i <= 17; i++) send(8'(i), 1'b1);
        chk("full_count", 32'(fifo_count), 16);
        chk("full_ovr", 32'(overrun), 1);
        for (int i = 1; i <= 16; i++) pop_chk($sformatf("full_pop%0d", i), 8'(i));
        chk("full_drained", 32'(fifo_count), 0);
        chk("full_ovr_sticky", 32'(overrun), 1);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        chk("ovr_cleared", 32'(overrun), 0);

        send(8'h3C, 1'b0);
        rx = 1'b0;
        chk("fe_set", 32'(frame_err), 1);
        chk("fe_count", 32'(fifo_count), 0);
        tick(40);
        rx = 1'b1;
        tick(90);
        chk("fe_break_count", 32'(fifo_count), 0);
        send(8'h7E, 1'b1);
        chk("fe_next_count", 32'(fifo_count), 1);
        pop_chk("fe_next_data", 8'h7E);
        chk("fe_sticky", 32'(frame_err), 1);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        chk("fe_cleared", 32'(frame_err), 0);

        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(20);
        chk("glitch_count", 32'(fifo_count), 0);
        chk("glitch_ovr", 32'(overrun), 0);
        chk("glitch_fe", 32'(frame_err), 0);
        send(8'h81, 1'b1);
        chk("glitch_next_count", 32'(fifo_count), 1);
        pop_chk("glitch_next_data", 8'h81);

        send(8'h33, 1'b0);
        tick(90);
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        chk("pre_rst_count", 32'(fifo_count), 2);
        chk("pre_rst_fe", 32'(frame_err), 1);
        rx = 1'b0;
        tick(CPB * 4 + CPB / 2);
        reset = 1'b1;
        tick(2);
        chk("midrst_count", 32'(fifo_count), 0);
        chk("midrst_valid", 32'(rx_valid), 0);
        chk("midrst_fe", 32'(frame_err), 0);
        chk("midrst_ovr", 32'(overrun), 0);
        reset = 1'b0;
        tick(CPB * 4 + CPB / 2);
        rx = 1'b1;
        tick(CPB);
        chk("tail_count", 32'(fifo_count), 0);
        chk("tail_fe", 32'(frame_err), 0);
        tick(90);
        send(8'hC3, 1'b1);
        chk("post_rst_count", 32'(fifo_count), 1);
        pop_chk("post_rst_data", 8'hC3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/simple_uart_rx.md
Name: simple_uart_rx

Overview:
- Receive-direction companion to the CPU's write-only console transmitter: host-to-board byte path into the CPU.
- Deserialises an asynchronous 8N1 serial line (`rx`) in the system clock domain and buffers bytes in a 16-entry FIFO.
- Presents bytes to the CPU's memory-mapped load path through a first-word-fall-through read port.
- Reports sticky overrun and framing errors.

Parameters:
- CLKS_PER_BIT, 434, system clocks per serial bit (50 MHz / 115200); must be ≥ 4.
- FIFO_DEPTH, 16, byte entries; power of two.
- FIFO_AW, 4, log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock (CLOCK_50 domain)
- reset  input  1  synchronous, active-high reset
- rx  input  1  asynchronous serial line, idle high
- read_en  input  1  pop head byte this cycle (single-cycle pulse from CPU load decode)
- read_data  output  8  head of FIFO, combinational; 8'h00 when empty
- rx_valid  output  1  FIFO not empty
- fifo_count  output  FIFO_AW+1  bytes held, 0..FIFO_DEPTH
- overrun  output  1  sticky: byte dropped because FIFO full
- frame_err  output  1  sticky: stop bit sampled low
- clear_err  input  1  clears overrun and frame_err

Behaviour:
- Interface decided: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values:
  - FIFO empty: rx_valid=0, fifo_count=0, read_data=8'h00.
  - overrun=0, frame_err=0.
  - Synchroniser flops = 1.
  - FSM = WAIT_IDLE, bit counter = 0.
- Input path: `rx` passes through a 2-flop synchroniser (rx_s). All FSM decisions use rx_s only.
- FSM states: WAIT_IDLE, IDLE, START, DATA, STOP.
- WAIT_IDLE:
  - Counts consecutive rx_s=1 cycles; any 0 restarts the count.
  - After 10*CLKS_PER_BIT consecutive highs -> IDLE.
  - Guarantees a reset or error mid-frame never decodes the frame tail as a start bit.
- IDLE: rx_s=0 -> START, clk counter cleared.
- START:
  - At counter == CLKS_PER_BIT/2 - 1 (integer division), sample rx_s.
  - 0 -> DATA, counter cleared, bit index 0.
  - 1 -> IDLE (glitch rejected; no flag).
- DATA:
  - Every CLKS_PER_BIT cycles, sample rx_s into shift register, LSB first.
  - After bit index 7 -> STOP.
- STOP: after CLKS_PER_BIT cycles, sample rx_s.
  - 1 and FIFO accepts -> push byte -> IDLE.
  - 1 and FIFO full (no simultaneous pop) -> byte dropped, overrun<=1 -> IDLE.
  - 0 -> byte discarded, frame_err<=1 -> WAIT_IDLE (covers break condition).
- Latency: push occurs 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT (±1) cycles after the pin falling edge. rx_valid rises the cycle after the push.
- FIFO:
  - Circular buffer with FIFO_AW-bit pointers, wrapping at FIFO_DEPTH.
  - fifo_count distinguishes full (FIFO_DEPTH) from empty (0).
  - read_en with rx_valid=1: rptr advances at the edge; read_data shows the next byte the following cycle.
  - read_en while empty: ignored; no state change.
  - Push and pop in the same cycle: both performed; count unchanged.
  - Full + pop + push in the same cycle: push accepted, no overrun.
- Error flags:
  - Set-dominant: clear_err in the same cycle as a new error leaves that flag at 1.
  - Flags never affect reception.
- Reset asserted mid-frame: all state returns to reset values. The partial frame is never pushed.

Test Plan (CLKS_PER_BIT=8 in bench):
- Send 0x55 after 80 idle cycles -> rx_valid=1 within 2+4+72±2 cycles of the falling edge; read_data=0x55; pulse read_en -> rx_valid=0, fifo_count=0, read_data=0x00.
- Back-to-back 0x00, 0xFF, 0xA5, no idle gap -> fifo_count=3; three pops return 0x00, 0xFF, 0xA5 in order; no flags set.
- Send 17 bytes 0x01..0x11 without reading -> fifo_count=16, overrun=1; pops return 0x01..0x10; 0x11 absent; clear_err -> overrun=0.
- 0x3C with stop bit 0, then line low 40 cycles, then high 80 cycles, then 0x7E -> frame_err=1, fifo_count=0 until 0x7E; only 0x7E is received.
- rx low for 2 cycles, then high -> no push, no flags, FSM back in IDLE; next 0x81 received correctly.
- Reset asserted during bit 3 of 0x00 with 2 bytes queued -> fifo_count=0, flags 0, no push from the truncated frame; after 80 idle cycles, 0xC3 is received.
